// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LoongArch IF stage: one-outstanding inst SRAM fetch, redirects, fs2ds handoff
// Optional FS_ADEF_EN: misaligned fetch addresses skip SRAM and raise adef on fs2ds_bus.
`ifndef FS2DS_BUS_LEN
`ifdef FS_ADEF_EN
`define FS2DS_BUS_LEN 65
`else
`define FS2DS_BUS_LEN 64
`endif
`endif

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ds_allowin,
   output logic                      fs2ds_valid,
   output logic [`FS2DS_BUS_LEN-1:0] fs2ds_bus,
   input  logic [32:0]               br_zip,
   input  logic                      wb_ex,
   input  logic [31:0]               ex_entry,
   output logic                      inst_sram_req,
   output logic                      inst_sram_wr,
   output logic [1:0]                inst_sram_size,
   output logic [3:0]                inst_sram_wstrb,
   output logic [31:0]               inst_sram_addr,
   output logic [31:0]               inst_sram_wdata,
   input  logic                      inst_sram_addr_ok,
   input  logic                      inst_sram_data_ok,
   input  logic [31:0]               inst_sram_rdata
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID} state_t;

   state_t                    state_q, state_d;
   logic [31:0]               pc_q, pc_d;
   logic [31:0]               fetch_pc_q, fetch_pc_d;
   logic [31:0]               redir_pc_q, redir_pc_d;
   logic                      redir_valid_q, redir_valid_d;
   logic                      drop_q, drop_d;
   logic                      valid_q, valid_d;
   logic [`FS2DS_BUS_LEN-1:0] bus_q, bus_d;
   logic                      first_q;

   logic                      redirect;
   logic [31:0]               redirect_pc;
   logic [31:0]               req_addr;
   logic                      hs;
   logic [`FS2DS_BUS_LEN-1:0] data_bus;

   // A redirect seen on the first clock after reset release is stale and ignored.
   assign redirect    = (wb_ex | br_zip[32]) & ~first_q;
   assign redirect_pc = wb_ex ? ex_entry : br_zip[31:0];
   assign req_addr    = redir_valid_q ? redir_pc_q : pc_q;
   assign hs          = inst_sram_req & inst_sram_addr_ok;

`ifdef FS_ADEF_EN
   logic                      misaligned;
   logic [`FS2DS_BUS_LEN-1:0] adef_bus;
   assign misaligned    = |req_addr[1:0];
   assign adef_bus      = {1'b1, req_addr, 32'h0};
   assign data_bus      = {1'b0, fetch_pc_q, inst_sram_rdata};
   assign inst_sram_req = (state_q == S_REQ) & ~misaligned & ~reset;
`else
   assign data_bus      = {fetch_pc_q, inst_sram_rdata};
   assign inst_sram_req = (state_q == S_REQ) & ~reset;
`endif

   assign inst_sram_addr  = req_addr;
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'b10;
   assign inst_sram_wstrb = 4'h0;
   assign inst_sram_wdata = 32'h0;
   assign fs2ds_valid     = valid_q;
   assign fs2ds_bus       = bus_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_pc_d    = fetch_pc_q;
      redir_pc_d    = redir_pc_q;
      redir_valid_d = redir_valid_q;
      drop_d        = drop_q;
      valid_d       = valid_q;
      bus_d         = bus_q;

      if (redirect) begin
         redir_valid_d = 1'b1;
         redir_pc_d    = redirect_pc;
      end

      case (state_q)
         S_REQ: begin
            if (redirect) begin
               // The accepted request is already wrong-path; its data must be discarded.
               if (hs) begin
                  fetch_pc_d = req_addr;
                  drop_d     = 1'b1;
                  state_d    = S_WAIT;
               end
`ifdef FS_ADEF_EN
            end else if (misaligned) begin
               bus_d         = adef_bus;
               valid_d       = 1'b1;
               redir_valid_d = 1'b0;
               pc_d          = req_addr + 32'd4;
               state_d       = S_VALID;
`endif
            end else if (hs) begin
               fetch_pc_d    = req_addr;
               redir_valid_d = 1'b0;
               state_d       = S_WAIT;
            end
         end
         S_WAIT: begin
            if (inst_sram_data_ok) begin
               if (drop_q || redirect) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  bus_d   = data_bus;
                  valid_d = 1'b1;
                  pc_d    = fetch_pc_q + 32'd4;
                  state_d = S_VALID;
               end
            end else if (redirect) begin
               drop_d = 1'b1;
            end
         end
         S_VALID: begin
            if (redirect || ds_allowin) begin
               valid_d = 1'b0;
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         fetch_pc_q    <= 32'h0;
         redir_pc_q    <= 32'h0;
         redir_valid_q <= 1'b0;
         drop_q        <= 1'b0;
         valid_q       <= 1'b0;
         bus_q         <= '0;
         first_q       <= 1'b1;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_pc_q    <= fetch_pc_d;
         redir_pc_q    <= redir_pc_d;
         redir_valid_q <= redir_valid_d;
         drop_q        <= drop_d;
         valid_q       <= valid_d;
         bus_q         <= bus_d;
         first_q       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against an instruction-stream model
module tb_fetch_stage;
`ifdef FS_ADEF_EN
   localparam int BL = 65;
`else
   localparam int BL = 64;
`endif
   localparam logic [31:0] RST_PC = 32'h1C00_0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          ds_allowin;
   logic          fs2ds_valid;
   logic [BL-1:0] fs2ds_bus;
   logic [32:0]   br_zip;
   logic          wb_ex;
   logic [31:0]   ex_entry;
   logic          inst_sram_req, inst_sram_wr;
   logic [1:0]    inst_sram_size;
   logic [3:0]    inst_sram_wstrb;
   logic [31:0]   inst_sram_addr, inst_sram_wdata;
   logic          inst_sram_addr_ok, inst_sram_data_ok;
   logic [31:0]   inst_sram_rdata;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset), .ds_allowin(ds_allowin),
      .fs2ds_valid(fs2ds_valid), .fs2ds_bus(fs2ds_bus),
      .br_zip(br_zip), .wb_ex(wb_ex), .ex_entry(ex_entry),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata)
   );

   int          checks = 0;
   int          failures = 0;
   int          addr_ok_pct, allow_pct, lat_min, lat_max;
   logic        pend;
   logic [31:0] pend_addr;
   int          pend_lat;
   logic [31:0] exp_pc;
   int          xfers;
   logic [31:0] hs_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [BL-1:0] exp_bus(input logic [31:0] pc);
      logic [BL-1:0] b;
      b = '0;
      b[63:0] = {pc, mem_word(pc)};
      return b;
   endfunction

   // One clock: SRAM slave + ID sink drive inputs at negedge; model tracks the expected stream.
   task automatic cycle(input logic br, input logic [31:0] tgt, input logic wbx,
                        input logic [31:0] entry, input logic stall);
      @(negedge clk);
      inst_sram_data_ok = pend && (pend_lat == 0);
      inst_sram_rdata   = pend ? mem_word(pend_addr) : 32'hDEAD_BEEF;
      inst_sram_addr_ok = ($urandom_range(1, 100) <= addr_ok_pct);
      ds_allowin        = !stall && !(br || wbx) && ($urandom_range(1, 100) <= allow_pct);
      br_zip            = {br, tgt};
      wb_ex             = wbx;
      ex_entry          = entry;
      if (inst_sram_req && inst_sram_addr_ok) begin
         checks++;
         if (pend) begin
            failures++;
            $display("FAIL outstanding: handshake at %h while %h still pending", inst_sram_addr, pend_addr);
         end
         hs_q.push_back(inst_sram_addr);
      end
      if (fs2ds_valid && ds_allowin) begin
         checks++;
         if (fs2ds_bus !== exp_bus(exp_pc)) begin
            failures++;
            $display("FAIL transfer: got %h expected %h", fs2ds_bus, exp_bus(exp_pc));
         end
         exp_pc = exp_pc + 32'd4;
         xfers++;
      end
      if (br || wbx) exp_pc = wbx ? entry : tgt;
      if (inst_sram_data_ok) pend = 1'b0;
      else if (pend) pend_lat--;
      if (inst_sram_req && inst_sram_addr_ok) begin
         pend      = 1'b1;
         pend_addr = inst_sram_addr;
         pend_lat  = $urandom_range(lat_min, lat_max);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic stall);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, stall);
   endtask

   task automatic apply_reset(input logic [32:0] br_at_release);
      @(negedge clk);
      reset = 1'b1;
      ds_allowin = 1'b0; br_zip = '0; wb_ex = 1'b0; ex_entry = '0;
      inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
      pend = 1'b0; pend_lat = 0; xfers = 0; hs_q.delete(); exp_pc = RST_PC;
      addr_ok_pct = 100; allow_pct = 100; lat_min = 0; lat_max = 0;
      @(negedge clk);
      reset = 1'b0;
      br_zip = br_at_release;
   endtask

   task automatic wait_first_hs();
      for (int i = 0; i < 20 && hs_q.size() == 0; i++) idle(1'b0);
      checks++;
      if (hs_q.size() == 0) begin
         failures++;
         $display("FAIL first_hs: no handshake within budget, got 0 required 1");
      end
   endtask

   task automatic run_xfers(input int n, input string name);
      for (int i = 0; i < 200 && xfers < n; i++) idle(1'b0);
      checks++;
      if (xfers < n) begin
         failures++;
         $display("FAIL %s: transfers got %0d required %0d", name, xfers, n);
      end
   endtask

   task automatic check_hs(input int idx, input logic [31:0] want, input string name);
      checks++;
      if (hs_q.size() <= idx) begin
         failures++;
         $display("FAIL %s: handshake %0d missing, required addr %h", name, idx, want);
      end else if (hs_q[idx] !== want) begin
         failures++;
         $display("FAIL %s: handshake addr got %h required %h", name, hs_q[idx], want);
      end
   endtask

   task automatic test_reset();
      apply_reset({1'b1, 32'h1C00_0400});
      checks++;
      if (fs2ds_valid !== 1'b0 || fs2ds_bus !== '0 || inst_sram_req !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: valid=%b bus=%h req=%b required 0/0/0", fs2ds_valid, fs2ds_bus, inst_sram_req);
      end
      checks++;
      if (inst_sram_wr !== 1'b0 || inst_sram_size !== 2'b10 || inst_sram_wstrb !== 4'h0 || inst_sram_wdata !== 32'h0) begin
         failures++;
         $display("FAIL ties: wr=%b size=%b wstrb=%h wdata=%h required 0/10/0/0",
                  inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
      end
      wait_first_hs();
      check_hs(0, RST_PC, "release_redirect_ignored");
      run_xfers(1, "reset_first_inst");
   endtask

   task automatic test_sequential();
      int n;
      apply_reset('0);
      n = 0;
      for (int i = 0; i < 40 && xfers < 3; i++) begin
         idle(1'b0);
         n++;
      end
      checks++;
      if (xfers < 3 || n < 9) begin
         failures++;
         $display("FAIL seq_throughput: %0d transfers in %0d cycles, required 3 in >= 9", xfers, n);
      end
      check_hs(0, 32'h1C00_0000, "seq_addr0");
      check_hs(1, 32'h1C00_0004, "seq_addr1");
      check_hs(2, 32'h1C00_0008, "seq_addr2");
   endtask

   task automatic test_stall();
      apply_reset('0);
      for (int i = 0; i < 20 && !fs2ds_valid; i++) idle(1'b1);
      for (int i = 0; i < 10; i++) begin
         idle(1'b1);
         checks++;
         if (fs2ds_valid !== 1'b1 || fs2ds_bus !== exp_bus(RST_PC) || inst_sram_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold: valid=%b bus=%h req=%b required 1/%h/0",
                     fs2ds_valid, fs2ds_bus, inst_sram_req, exp_bus(RST_PC));
         end
      end
      run_xfers(2, "stall_release");
      check_hs(1, 32'h1C00_0004, "stall_next_addr");
   endtask

   task automatic test_branch_drop();
      apply_reset('0);
      lat_min = 3; lat_max = 3;
      wait_first_hs();
      cycle(1'b1, 32'h1C00_0100, 1'b0, 32'h0, 1'b0);
      lat_min = 0; lat_max = 0;
      run_xfers(1, "branch_drop");
      check_hs(1, 32'h1C00_0100, "branch_target");
   endtask

   task automatic test_wb_priority();
      apply_reset('0);
      wait_first_hs();
      cycle(1'b1, 32'h1C00_0100, 1'b1, 32'h1C00_8000, 1'b0);
      run_xfers(1, "wb_priority");
      check_hs(1, 32'h1C00_8000, "wb_target");
   endtask

   task automatic test_addr_ok_stall();
      apply_reset('0);
      addr_ok_pct = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) cycle(1'b1, 32'h1C00_0200, 1'b0, 32'h0, 1'b0);
         else idle(1'b0);
         checks++;
         if (inst_sram_req !== 1'b1 || inst_sram_addr !== (i >= 2 ? 32'h1C00_0200 : RST_PC)) begin
            failures++;
            $display("FAIL addr_ok_stall: req=%b addr=%h required 1/%h", inst_sram_req, inst_sram_addr,
                     (i >= 2 ? 32'h1C00_0200 : RST_PC));
         end
      end
      addr_ok_pct = 100;
      run_xfers(1, "addr_ok_stall_xfer");
      checks++;
      if (hs_q.size() != 1) begin
         failures++;
         $display("FAIL single_handshake: got %0d handshakes required 1", hs_q.size());
      end
      check_hs(0, 32'h1C00_0200, "addr_ok_stall_target");
   endtask

   task automatic test_wrap();
      apply_reset('0);
      addr_ok_pct = 70; allow_pct = 70; lat_max = 2;
      wait_first_hs();
      cycle(1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0);
      run_xfers(3, "wrap");
      check_hs(hs_q.size() > 0 ? hs_q.size() - 1 : 0, 32'h0000_0000, "wrap_zero");
   endtask

`ifdef FS_ADEF_EN
   task automatic test_adef();
      logic [BL-1:0] want;
      int            n_hs;
      apply_reset('0);
      wait_first_hs();
      n_hs = hs_q.size();
      cycle(1'b1, 32'h1C00_0102, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 20 && !fs2ds_valid; i++) idle(1'b1);
      want = {1'b1, 32'h1C00_0102, 32'h0};
      checks++;
      if (fs2ds_valid !== 1'b1 || fs2ds_bus !== want) begin
         failures++;
         $display("FAIL adef_bus: valid=%b bus=%h required 1/%h", fs2ds_valid, fs2ds_bus, want);
      end
      checks++;
      if (hs_q.size() != n_hs) begin
         failures++;
         $display("FAIL adef_no_req: handshakes got %0d required %0d", hs_q.size(), n_hs);
      end
   endtask
`endif

   task automatic test_random();
      logic        br, wbx;
      logic [31:0] tgt, ent;
      apply_reset('0);
      for (int i = 0; i < 800; i++) begin
         addr_ok_pct = $urandom_range(20, 100);
         allow_pct   = $urandom_range(20, 100);
         lat_max     = $urandom_range(0, 4);
         br  = ($urandom_range(0, 99) < 5);
         wbx = ($urandom_range(0, 99) < 3);
         tgt = {$urandom(), 2'b00} >> 0;
         tgt[1:0] = 2'b00;
         ent = $urandom();
         ent[1:0] = 2'b00;
         cycle(br, tgt, wbx, ent, 1'b0);
      end
      lat_max = 0;
      checks++;
      if (xfers < 50) begin
         failures++;
         $display("FAIL random_progress: transfers got %0d required >= 50", xfers);
      end
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_sequential();
      test_stall();
      test_branch_drop();
      test_wb_priority();
      test_addr_ok_stall();
      test_wrap();
`ifdef FS_ADEF_EN
      test_adef();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
